// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_OFFSET = 5;
    localparam int BEAT_IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/burst_mem_array.sv
// Beat-granular line storage: one 64-bit word per {line index, beat}.
// Combinational read, synchronous write; the controller registers the read data.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int LINE_IDX_BITS = 10
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [LINE_IDX_BITS+BEAT_IDX_W-1:0] waddr,
    input  logic [BEAT_W-1:0]                   wdata,
    input  logic [LINE_IDX_BITS+BEAT_IDX_W-1:0] raddr,
    output logic [BEAT_W-1:0]                   rdata
);

    localparam int DEPTH = (2 ** LINE_IDX_BITS) * BEATS;

    logic [BEAT_W-1:0] mem_q [DEPTH];

    // Commit one write beat per enabled clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/burst_mem_responder.sv
// Responder side of the 4-beat, 64-bit line burst interface, backed by an
// internal array. One transaction at a time; beats follow a fixed latency.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LINE_IDX_BITS = 10,
    parameter int LATENCY       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [BEAT_W-1:0] mem_wdata,
    output logic              mem_resp,
    output logic [BEAT_W-1:0] mem_rdata,
    output logic              proto_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BEAT_IDX_W-1:0]    beat_q, beat_d;
    logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
    logic                     is_wr_q, is_wr_d;
    logic                     resp_q, resp_d;
    logic [BEAT_W-1:0]        rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic                     req_held;
    logic                     arr_we;
    logic [BEAT_W-1:0]        arr_rdata;

    // Offset bits and the aliased upper bits do not select anything.
    logic unused_addr;
    assign unused_addr = ^{mem_address[31:LINE_IDX_BITS+LINE_OFFSET],
                           mem_address[LINE_OFFSET-1:0]};

    // The request that was accepted must stay up until its last beat.
    assign req_held = is_wr_q ? mem_write : mem_read;

    // Next-state, counter and error logic for one-transaction-at-a-time FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    idx_d   = mem_address[LINE_IDX_BITS+LINE_OFFSET-1:LINE_OFFSET];
                    is_wr_d = mem_write;
                    beat_d  = '0;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            WAIT: begin
                if (!req_held) begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!req_held) begin
                    err_d = 1'b1;
                end
                if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BEAT_IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are computed from the next state and
    // the next beat; the array is looked up one cycle ahead of the beat.
    always_comb begin
        resp_d  = (state_d == BURST);
        rdata_d = (state_d == BURST && !is_wr_d) ? arr_rdata : '0;
    end

    // Write beats land at the edge closing each resp cycle; a reset on that
    // edge drops the beat so an aborted line is only partially updated.
    assign arr_we = (state_q == BURST) && is_wr_q && !rst;

    burst_mem_array #(
        .LINE_IDX_BITS (LINE_IDX_BITS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr ({idx_q, beat_q}),
        .wdata (mem_wdata),
        .raddr ({idx_d, beat_d}),
        .rdata (arr_rdata)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            is_wr_q <= is_wr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;
    assign proto_err = err_q;

endmodule
